counter_ctrl: RTL and testbench

//  Command-driven sequencer placed directly upstream of the loadable counter.
//  - Accepts a (start, stop) command over a valid/ready handshake.
//  - Drives the counter's load/enab/cnt_in, watches its cnt_out, and pulses done when cnt_out reaches stop.
//  - Aborts clear the counter through its synchronous reset input.

---
 rtl/counter_pkg.sv | 14 +
 rtl/counter_ctrl_if.sv | 27 ++
 rtl/counter.sv | 27 ++
 rtl/counter_ctrl.sv | 95 +++++++++
 tb/tb_counter_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequencer: controller state encoding
// and the default counter width.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/counter_ctrl_if.sv
// Command handshake between a requester and the counter sequencer.
// The master offers a (start, stop) pair with cmd_valid.
// The slave accepts it on an edge where cmd_ready is also high.
interface counter_ctrl_if #(
    parameter int WIDTH = counter_pkg::DEFAULT_WIDTH
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_start;
    logic [WIDTH-1:0] cmd_stop;

    modport master (
        output cmd_valid,
        output cmd_start,
        output cmd_stop,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_start,
        input  cmd_stop,
        output cmd_ready
    );

endinterface

// File: rtl/counter.sv
// Loadable up-counter driven by counter_ctrl.
// Its active-high synchronous clear has priority over load, and load has
// priority over count enable. It has no asynchronous reset, so a controller
// reset leaves the count untouched.
module counter #(
    parameter int WIDTH = counter_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out
);

    // Clear, load or increment (modulo 2^WIDTH) on each rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_out <= '0;
        end else if (load) begin
            cnt_out <= cnt_in;
        end else if (enab) begin
            cnt_out <= cnt_out + 1'b1;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Command-driven sequencer for the loadable counter.
// A command loads cnt_in = start for one cycle. The counter then runs until
// cnt_out equals stop, and done pulses one cycle after the match.
// abort returns the controller to IDLE and clears the counter through cnt_clr.
// Optional feature: define COUNTER_CTRL_AUTORELOAD_EN to re-load start after
// every match instead of finishing. The block then stays busy until an abort.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    counter_ctrl_if.slave    cmd,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_out,
    output logic [WIDTH-1:0] cnt_in,
    output logic             load,
    output logic             enab,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done
);

    ctrl_state_t      state;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] stop_q;
    logic             done_q;
    logic             abort_eff;
    logic             accept;
    logic             match;

    // abort has no effect while rst_n is low, so ready stays high and
    // the counter is not cleared during reset.
    assign abort_eff = abort & rst_n;
    assign accept    = cmd.cmd_valid & cmd.cmd_ready;
    assign match     = (cnt_out == stop_q);

    // Sequencer state, latched command and registered done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            start_q <= '0;
            stop_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            start_q <= cmd.cmd_start;
                            stop_q  <= cmd.cmd_stop;
                            state   <= LOAD;
                        end
                    end
                    LOAD: begin
                        state <= RUN;
                    end
                    RUN: begin
                        if (match) begin
                            done_q <= 1'b1;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
                            state  <= LOAD;
`else
                            state  <= DONE;
`endif
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Counter controls are decoded from the state. In RUN, enab drops in
    // the same cycle that cnt_out reaches stop, so the count holds there.
    always_comb begin
        cmd.cmd_ready = (state == IDLE) & ~abort_eff;
        busy          = (state != IDLE);
        load          = (state == LOAD);
        enab          = (state == LOAD) | ((state == RUN) & ~match);
        cnt_clr       = abort_eff;
        cnt_in        = start_q;
        done          = done_q;
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl driving the loadable counter.
// The reference model tracks each command as a cycle index since acceptance.
// Expected outputs and counts come from the command's run length with plain
// arithmetic. Honours COUNTER_CTRL_AUTORELOAD_EN when it is defined.
module tb_counter_ctrl;
    import counter_pkg::*;

    localparam int W   = DEFAULT_WIDTH;
    localparam int MOD = 1 << W;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] cnt_out;
    logic [W-1:0] cnt_in;
    logic         load;
    logic         enab;
    logic         cnt_clr;
    logic         busy;
    logic         done;

    counter_ctrl_if #(.WIDTH(W)) cmd_if ();

    counter_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cmd     (cmd_if),
        .abort   (abort),
        .cnt_out (cnt_out),
        .cnt_in  (cnt_in),
        .load    (load),
        .enab    (enab),
        .cnt_clr (cnt_clr),
        .busy    (busy),
        .done    (done)
    );

    counter #(.WIDTH(W)) u_counter (
        .clk     (clk),
        .rst     (cnt_clr),
        .load    (load),
        .enab    (enab),
        .cnt_in  (cnt_in),
        .cnt_out (cnt_out)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Model: m_k is the cycle index since acceptance.
    // 1 is the load cycle, 2..m_n+1 the run cycles, m_n+2 the done cycle.
    bit m_active;
    int m_k;
    int m_n;
    int m_start;
    int m_cnt;
    bit m_cnt_known;
    bit m_done;

    int vectors     = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compareAll(input logic a);
        bit eLoad;
        bit eEnab;
        eLoad = m_active && (m_k == 1);
        eEnab = m_active && ((m_k == 1) || (m_k >= 2 && m_k <= m_n));
        checkOutput("busy",      32'(busy),          32'(m_active));
        checkOutput("cmd_ready", 32'(cmd_if.cmd_ready), 32'(!m_active && !a));
        checkOutput("load",      32'(load),          32'(eLoad));
        checkOutput("enab",      32'(enab),          32'(eEnab));
        checkOutput("done",      32'(done),          32'(m_done));
        checkOutput("cnt_clr",   32'(cnt_clr),       32'(a));
        checkOutput("cnt_in",    32'(cnt_in),        32'(m_start));
        if (m_cnt_known) begin
            checkOutput("cnt_out", 32'(cnt_out), 32'(m_cnt));
        end
    endtask

    task automatic modelStep(input logic v, input logic [W-1:0] s, input logic [W-1:0] e, input logic a);
        bit nextDone;
        int si;
        int ei;
        nextDone = 1'b0;
        si = int'(s);
        ei = int'(e);
        if (a) begin
            m_active    = 1'b0;
            m_k         = 0;
            m_cnt       = 0;
            m_cnt_known = 1'b1;
        end else if (m_active) begin
            if (m_k == m_n + 1) begin
                nextDone = 1'b1;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
                m_k = 1;
`else
                m_k = m_n + 2;
`endif
            end else if (m_k == m_n + 2) begin
                m_active = 1'b0;
                m_k      = 0;
            end else begin
                m_k++;
            end
            if (m_active && m_k >= 2 && m_k <= m_n + 1) begin
                m_cnt       = (m_start + m_k - 2) % MOD;
                m_cnt_known = 1'b1;
            end
        end else if (v) begin
            m_active = 1'b1;
            m_k      = 1;
            m_start  = si;
            m_n      = ((ei - si + MOD) % MOD) + 1;
        end
        m_done = nextDone;
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] s, input logic [W-1:0] e, input logic a);
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = v;
        cmd_if.cmd_start = s;
        cmd_if.cmd_stop  = e;
        abort            = a;
        @(negedge clk);
        compareAll(a);
        modelStep(v, s, e, a);
    endtask

    task automatic runCmd(input logic [W-1:0] s, input logic [W-1:0] e, input bit randomAbort);
        int bound;
        logic a;
        applyStimulus(1'b1, s, e, 1'b0);
        bound = m_n + 3;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
        bound = 3 * (m_n + 1) + 1;
`endif
        for (int i = 0; i < bound && m_active; i++) begin
            a = randomAbort && ($urandom_range(0, 31) == 0);
            applyStimulus(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), a);
        end
`ifdef COUNTER_CTRL_AUTORELOAD_EN
        if (m_active) begin
            applyStimulus(1'b0, '0, '0, 1'b1);
        end
        repeat (2) applyStimulus(1'b0, '0, '0, 1'b0);
`endif
    endtask

    // Assert reset mid-cycle: outputs go to reset values immediately and
    // abort is ignored. The counter keeps its value.
    task automatic doReset();
        @(posedge clk);
        #2;
        rst_n            = 1'b0;
        abort            = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        #1;
        m_active = 1'b0;
        m_k      = 0;
        m_start  = 0;
        m_done   = 1'b0;
        compareAll(1'b0);
        @(negedge clk);
        compareAll(1'b0);
        @(posedge clk);
        #1;
        rst_n            = 1'b1;
        abort            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
    endtask

    // Safety net so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        logic [W-1:0] s;
        logic [W-1:0] e;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_start = '0;
        cmd_if.cmd_stop  = '0;
        m_active    = 1'b0;
        m_k         = 0;
        m_n         = 0;
        m_start     = 0;
        m_cnt       = 0;
        m_cnt_known = 1'b0;
        m_done      = 1'b0;

        @(negedge clk);
        compareAll(1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(1'b0, '0, '0, 1'b1);
        applyStimulus(1'b1, 9'h005, 9'h006, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0);

        $display("[TB] basic command 0x015 -> 0x01A");
        runCmd(9'h015, 9'h01A, 1'b0);
        $display("[TB] start equals stop 0x00A");
        runCmd(9'h00A, 9'h00A, 1'b0);
        $display("[TB] wrapping command 0x1FE -> 0x001");
        runCmd(9'h1FE, 9'h001, 1'b0);

        $display("[TB] abort at count 0x018");
        applyStimulus(1'b1, 9'h015, 9'h01A, 1'b0);
        for (int i = 0; i < 20 && m_cnt != 32'h018; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0);
        end
        applyStimulus(1'b1, 9'h015, 9'h01A, 1'b1);
        repeat (3) applyStimulus(1'b0, '0, '0, 1'b0);

        $display("[TB] reset during run");
        applyStimulus(1'b1, 9'h020, 9'h030, 1'b0);
        repeat (4) applyStimulus(1'b0, '0, '0, 1'b0);
        doReset();
        applyStimulus(1'b0, '0, '0, 1'b0);

`ifdef COUNTER_CTRL_AUTORELOAD_EN
        $display("[TB] autoreload 0x010 -> 0x012");
        runCmd(9'h010, 9'h012, 1'b0);
`endif

        $display("[TB] randomized commands");
        for (int c = 0; c < 40; c++) begin
            s = W'($urandom);
            e = W'((int'(s) + $urandom_range(0, 12)) % MOD);
            runCmd(s, e, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus(1'b0, '0, '0, 1'($urandom_range(0, 3) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
